gc_mss: RTL and testbench

GC_MSS -- requirements
Module: gc_mss

---
 rtl/gc_mss.sv | 275 +++++++++++++++++++++++++++
 tb/tb_gc_mss.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_mss.sv
// gc_mss: UART-controlled APB master with GPI readback and a 1-bit sigma-delta speaker DAC.
// Optional feature macro: GC_MSS_DAC_EN (builds the DAC level register and accumulator).
`timescale 1ns/1ps
module gc_mss #(
    parameter int BAUD_DIV    = 87,
    parameter int APB_TIMEOUT = 256
) (
    input  logic        SYSCLK,
    input  logic        MSS_RESET_N,
    output logic        FAB_CLK,
    output logic        M2F_RESET_N,
    output logic        MSSPSEL,
    output logic        MSSPENABLE,
    output logic        MSSPWRITE,
    output logic [19:0] MSSPADDR,
    output logic [31:0] MSSPWDATA,
    input  logic [31:0] MSSPRDATA,
    input  logic        MSSPREADY,
    input  logic        MSSPSLVERR,
    input  logic        F2M_GPI_0,
    input  logic        F2M_GPI_1,
    input  logic        F2M_GPI_2,
    input  logic        F2M_GPI_4,
    input  logic        UART_0_RXD,
    output logic        UART_0_TXD,
    input  logic        UART_1_RXD,
    output logic        UART_1_TXD,
    input  logic        SPI_0_DI,
    output logic        SPI_0_DO,
    inout  wire         SPI_0_CLK,
    inout  wire         SPI_0_SS,
    input  logic        VAREF0,
    output logic        SPEAKER_DAC
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(APB_TIMEOUT);
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] C_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMO_END  = TW'(APB_TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE    = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [7:0] CH_W = 8'h57, CH_R = 8'h52, CH_G = 8'h47, CH_D = 8'h44;
    localparam logic [7:0] CH_K = 8'h4B, CH_E = 8'h45, CH_T = 8'h54, CH_Q = 8'h3F;

    typedef enum logic [2:0] {S_IDLE, S_ARGS, S_SETUP, S_ACCESS, S_RESP} state_t;

    logic [1:0]    rst_sync_r;
    logic          srst_s, unused_s;
    logic          rx_meta_r, rx_sync_r, rx_busy_r, rx_valid_r;
    logic [3:0]    rx_bit_r;
    logic [CW-1:0] rx_cnt_r;
    logic [7:0]    rx_byte_r;
    logic          tx_busy_r, txd_r, tx_go_s;
    logic [3:0]    tx_bits_r;
    logic [CW-1:0] tx_cnt_r;
    logic [8:0]    tx_shift_r;
    state_t        state_r, state_n;
    logic [7:0]    cmd_r, cmd_n, d_resp_s;
    logic [2:0]    need_r, need_n, left_r, left_n;
    logic [43:0]   shift_r, shift_n;
    logic [51:0]   args_s;
    logic [19:0]   paddr_r, paddr_n;
    logic [31:0]   pwdata_r, pwdata_n;
    logic          pwrite_r, pwrite_n, psel_r, psel_n, penable_r, penable_n;
    logic [TW-1:0] tmo_r, tmo_n;
    logic [39:0]   resp_r, resp_n;

    assign FAB_CLK     = SYSCLK;
    assign M2F_RESET_N = rst_sync_r[1];
    assign srst_s      = ~rst_sync_r[1];
    assign MSSPSEL     = psel_r;
    assign MSSPENABLE  = penable_r;
    assign MSSPWRITE   = pwrite_r;
    assign MSSPADDR    = paddr_r;
    assign MSSPWDATA   = pwdata_r;
    assign UART_0_TXD  = txd_r;
    assign UART_1_TXD  = 1'b1;
    assign SPI_0_DO    = 1'b0;
    assign SPI_0_CLK   = 1'b0;
    assign SPI_0_SS    = 1'b1;
    assign unused_s    = ^{UART_1_RXD, SPI_0_DI, VAREF0};
    assign args_s      = {shift_r, rx_byte_r};

    // Fabric reset synchronizer; its output also acts as the internal soft reset.
    always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) rst_sync_r <= 2'b00;
        else              rst_sync_r <= {rst_sync_r[0], 1'b1};
    end

    // Two-flop synchronizer for the command UART input line.
    always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= UART_0_RXD;
            rx_sync_r <= rx_meta_r;
        end
    end

    // UART receiver: bit 0 is the start-bit check, 1..8 data, 9 stop.
    always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            rx_busy_r <= 1'b0; rx_valid_r <= 1'b0; rx_bit_r <= 4'd0;
            rx_cnt_r <= {CW{1'b0}}; rx_byte_r <= 8'h00;
        end else if (srst_s) begin
            rx_busy_r <= 1'b0; rx_valid_r <= 1'b0; rx_bit_r <= 4'd0;
            rx_cnt_r <= {CW{1'b0}}; rx_byte_r <= 8'h00;
        end else begin
            rx_valid_r <= 1'b0;
            if (!rx_busy_r) begin
                rx_cnt_r  <= {CW{1'b0}};
                rx_bit_r  <= 4'd0;
                rx_busy_r <= ~rx_sync_r;
            end else if (rx_cnt_r != ((rx_bit_r == 4'd0) ? HALF_END : BIT_END)) begin
                rx_cnt_r <= rx_cnt_r + C_ONE;
            end else begin
                rx_cnt_r <= {CW{1'b0}};
                case (rx_bit_r)
                    4'd0: begin rx_busy_r <= ~rx_sync_r; rx_bit_r <= 4'd1; end
                    4'd9: begin rx_busy_r <= 1'b0; rx_valid_r <= rx_sync_r; end
                    default: begin
                        rx_byte_r <= {rx_sync_r, rx_byte_r[7:1]};
                        rx_bit_r  <= rx_bit_r + 4'd1;
                    end
                endcase
            end
        end
    end

    // UART transmitter: start bit on launch, then 8 data bits and the stop bit.
    always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            tx_busy_r <= 1'b0; txd_r <= 1'b1; tx_bits_r <= 4'd0;
            tx_cnt_r <= {CW{1'b0}}; tx_shift_r <= 9'h1FF;
        end else if (srst_s) begin
            tx_busy_r <= 1'b0; txd_r <= 1'b1; tx_bits_r <= 4'd0;
            tx_cnt_r <= {CW{1'b0}}; tx_shift_r <= 9'h1FF;
        end else if (tx_go_s) begin
            tx_busy_r <= 1'b1; txd_r <= 1'b0; tx_bits_r <= 4'd9;
            tx_cnt_r <= {CW{1'b0}}; tx_shift_r <= {1'b1, resp_r[39:32]};
        end else if (!tx_busy_r) begin
            txd_r <= 1'b1;
        end else if (tx_cnt_r != BIT_END) begin
            tx_cnt_r <= tx_cnt_r + C_ONE;
        end else begin
            tx_cnt_r <= {CW{1'b0}};
            if (tx_bits_r == 4'd0) begin
                tx_busy_r <= 1'b0;
            end else begin
                txd_r      <= tx_shift_r[0];
                tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                tx_bits_r  <= tx_bits_r - 4'd1;
            end
        end
    end

`ifdef GC_MSS_DAC_EN
    logic [7:0] level_r;
    logic [8:0] acc_r;
    assign d_resp_s    = CH_K;
    assign SPEAKER_DAC = acc_r[8];

    // DAC level load on the 'D' data byte and first-order sigma-delta accumulator.
    always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            level_r <= 8'h00; acc_r <= 9'h000;
        end else if (srst_s) begin
            level_r <= 8'h00; acc_r <= 9'h000;
        end else begin
            if (state_r == S_ARGS && cmd_r == CH_D && rx_valid_r) level_r <= rx_byte_r;
            else                                                   level_r <= level_r;
            acc_r <= {1'b0, acc_r[7:0]} + {1'b0, level_r};
        end
    end
`else
    assign d_resp_s    = CH_E;
    assign SPEAKER_DAC = 1'b0;
`endif

    // Command engine state and APB/response datapath registers.
    always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            state_r <= S_IDLE; cmd_r <= 8'h00; need_r <= 3'd0; shift_r <= 44'h0;
            paddr_r <= 20'h0; pwdata_r <= 32'h0; pwrite_r <= 1'b0; psel_r <= 1'b0;
            penable_r <= 1'b0; tmo_r <= {TW{1'b0}}; resp_r <= 40'h0; left_r <= 3'd0;
        end else if (srst_s) begin
            state_r <= S_IDLE; cmd_r <= 8'h00; need_r <= 3'd0; shift_r <= 44'h0;
            paddr_r <= 20'h0; pwdata_r <= 32'h0; pwrite_r <= 1'b0; psel_r <= 1'b0;
            penable_r <= 1'b0; tmo_r <= {TW{1'b0}}; resp_r <= 40'h0; left_r <= 3'd0;
        end else begin
            state_r <= state_n; cmd_r <= cmd_n; need_r <= need_n; shift_r <= shift_n;
            paddr_r <= paddr_n; pwdata_r <= pwdata_n; pwrite_r <= pwrite_n; psel_r <= psel_n;
            penable_r <= penable_n; tmo_r <= tmo_n; resp_r <= resp_n; left_r <= left_n;
        end
    end

    // Next-state logic; UART bytes are only consumed in IDLE and ARGS.
    always_comb begin
        state_n = state_r; cmd_n = cmd_r; need_n = need_r; shift_n = shift_r;
        paddr_n = paddr_r; pwdata_n = pwdata_r; pwrite_n = pwrite_r; psel_n = psel_r;
        penable_n = penable_r; tmo_n = tmo_r; resp_n = resp_r; left_n = left_r;
        tx_go_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (rx_valid_r) begin
                    cmd_n = rx_byte_r;
                    case (rx_byte_r)
                        CH_W: begin need_n = 3'd7; state_n = S_ARGS; end
                        CH_R: begin need_n = 3'd3; state_n = S_ARGS; end
                        CH_D: begin need_n = 3'd1; state_n = S_ARGS; end
                        CH_G: begin
                            resp_n  = {CH_K, 4'b0000, F2M_GPI_4, F2M_GPI_2, F2M_GPI_1, F2M_GPI_0, 24'h000000};
                            left_n  = 3'd2;
                            state_n = S_RESP;
                        end
                        default: begin resp_n = {CH_Q, 32'h0}; left_n = 3'd1; state_n = S_RESP; end
                    endcase
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_ARGS: begin
                if (rx_valid_r) begin
                    shift_n = args_s[43:0];
                    if (need_r == 3'd1) begin
                        case (cmd_r)
                            CH_W: begin
                                paddr_n = args_s[51:32]; pwdata_n = args_s[31:0];
                                pwrite_n = 1'b1; psel_n = 1'b1; state_n = S_SETUP;
                            end
                            CH_R: begin
                                paddr_n = args_s[19:0]; pwrite_n = 1'b0;
                                psel_n = 1'b1; state_n = S_SETUP;
                            end
                            default: begin resp_n = {d_resp_s, 32'h0}; left_n = 3'd1; state_n = S_RESP; end
                        endcase
                    end else begin
                        need_n = need_r - 3'd1;
                    end
                end else begin
                    state_n = S_ARGS;
                end
            end
            S_SETUP: begin
                penable_n = 1'b1; tmo_n = {TW{1'b0}}; state_n = S_ACCESS;
            end
            S_ACCESS: begin
                if (MSSPREADY) begin
                    psel_n = 1'b0; penable_n = 1'b0; state_n = S_RESP;
                    if (MSSPSLVERR)     begin resp_n = {CH_E, 32'h0};     left_n = 3'd1; end
                    else if (pwrite_r)  begin resp_n = {CH_K, 32'h0};     left_n = 3'd1; end
                    else                begin resp_n = {CH_K, MSSPRDATA}; left_n = 3'd5; end
                end else if (tmo_r == TMO_END) begin
                    psel_n = 1'b0; penable_n = 1'b0; state_n = S_RESP;
                    resp_n = {CH_T, 32'h0}; left_n = 3'd1;
                end else begin
                    tmo_n = tmo_r + T_ONE;
                end
            end
            S_RESP: begin
                if (!tx_busy_r) begin
                    tx_go_s = 1'b1;
                    resp_n  = {resp_r[31:0], 8'h00};
                    left_n  = left_r - 3'd1;
                    if (left_r == 3'd1) state_n = S_IDLE;
                    else                state_n = S_RESP;
                end else begin
                    state_n = S_RESP;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_gc_mss.sv
// tb_gc_mss: directed plus randomized bench for gc_mss with a byte-level response model.
`timescale 1ns/1ps
module tb_gc_mss;
    localparam int BAUD = 16;
    localparam int TMO  = 256;
`ifdef GC_MSS_DAC_EN
    localparam bit DAC_EN = 1'b1;
`else
    localparam bit DAC_EN = 1'b0;
`endif

    logic SYSCLK = 1'b0;
    logic MSS_RESET_N, FAB_CLK, M2F_RESET_N, MSSPSEL, MSSPENABLE, MSSPWRITE;
    logic [19:0] MSSPADDR;
    logic [31:0] MSSPWDATA, MSSPRDATA;
    logic MSSPREADY, MSSPSLVERR, UART_0_RXD, UART_0_TXD, UART_1_RXD, UART_1_TXD;
    logic SPI_0_DI, SPI_0_DO, VAREF0, SPEAKER_DAC;
    logic [3:0] gpi;
    wire  spi_clk, spi_ss;

    int   n_cmp = 0, n_bad = 0, wait_cfg = 0;
    bit   never_ready = 1'b0;
    logic [7:0]  rx_q[$];
    logic [7:0]  mon_b;
    logic [19:0] q_addr[$];
    logic [31:0] q_data[$];
    bit          q_wr[$];
    int          q_set[$], q_acc[$];

    gc_mss #(.BAUD_DIV(BAUD), .APB_TIMEOUT(TMO)) dut (
        .SYSCLK(SYSCLK), .MSS_RESET_N(MSS_RESET_N), .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N),
        .MSSPSEL(MSSPSEL), .MSSPENABLE(MSSPENABLE), .MSSPWRITE(MSSPWRITE), .MSSPADDR(MSSPADDR),
        .MSSPWDATA(MSSPWDATA), .MSSPRDATA(MSSPRDATA), .MSSPREADY(MSSPREADY), .MSSPSLVERR(MSSPSLVERR),
        .F2M_GPI_0(gpi[0]), .F2M_GPI_1(gpi[1]), .F2M_GPI_2(gpi[2]), .F2M_GPI_4(gpi[3]),
        .UART_0_RXD(UART_0_RXD), .UART_0_TXD(UART_0_TXD), .UART_1_RXD(UART_1_RXD), .UART_1_TXD(UART_1_TXD),
        .SPI_0_DI(SPI_0_DI), .SPI_0_DO(SPI_0_DO), .SPI_0_CLK(spi_clk), .SPI_0_SS(spi_ss),
        .VAREF0(VAREF0), .SPEAKER_DAC(SPEAKER_DAC)
    );

    always #50 SYSCLK = ~SYSCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected response bytes (left-aligned) derived from the command and the slave's behaviour.
    // The status byte packs {GPI4, GPI2, GPI1, GPI0} into its low nibble.
    function automatic logic [39:0] model_resp(input logic [7:0] c, output int n);
        n = 1;
        case (c)
            8'h57, 8'h52: begin
                if (never_ready)           model_resp = {8'h54, 32'h0};
                else if (MSSPSLVERR)       model_resp = {8'h45, 32'h0};
                else if (c == 8'h57)       model_resp = {8'h4B, 32'h0};
                else begin n = 5;          model_resp = {8'h4B, MSSPRDATA}; end
            end
            8'h47: begin n = 2; model_resp = {8'h4B, 4'b0000, gpi, 24'h0}; end
            8'h44:   model_resp = {(DAC_EN ? 8'h4B : 8'h45), 32'h0};
            default: model_resp = {8'h3F, 32'h0};
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge SYSCLK);
        UART_0_RXD = 1'b0;
        repeat (BAUD) @(negedge SYSCLK);
        for (int i = 0; i < 8; i++) begin
            UART_0_RXD = b[i];
            repeat (BAUD) @(negedge SYSCLK);
        end
        UART_0_RXD = 1'b1;
        repeat (BAUD) @(negedge SYSCLK);
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d, input logic [7:0] db);
        send_byte(c);
        if (c == 8'h57 || c == 8'h52) begin
            for (int i = 2; i >= 0; i--) send_byte(a[8*i +: 8]);
        end
        if (c == 8'h57) begin
            for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
        end
        if (c == 8'h44) send_byte(db);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] c, input logic [23:0] a, input logic [31:0] d, input logic [7:0] db);
        logic [39:0] exp;
        int n, budget;
        rx_q.delete(); q_addr.delete(); q_data.delete(); q_wr.delete(); q_set.delete(); q_acc.delete();
        exp = model_resp(c, n);
        send_cmd(c, a, d, db);
        budget = (n + 1) * 12 * BAUD + TMO + 64;
        while (rx_q.size() < n && budget > 0) begin
            @(negedge SYSCLK);
            budget--;
        end
        check({tag, "_resp_len"}, 64'(rx_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) check({tag, "_resp_byte"}, 64'(rx_q[i]), 64'(exp[39-8*i -: 8]));
        end
        if (c == 8'h57 || c == 8'h52) begin
            check({tag, "_xfers"}, 64'(q_addr.size()), 64'd1);
            if (q_addr.size() > 0) begin
                check({tag, "_addr"}, 64'(q_addr[0]), 64'(a[19:0]));
                check({tag, "_write"}, 64'(q_wr[0]), 64'(c == 8'h57));
                if (c == 8'h57) check({tag, "_wdata"}, 64'(q_data[0]), 64'(d));
                check({tag, "_setup_cycles"}, 64'(q_set[0]), 64'd1);
                check({tag, "_access_cycles"}, 64'(q_acc[0]), 64'(never_ready ? TMO : wait_cfg + 1));
            end
        end else begin
            check({tag, "_xfers"}, 64'(q_addr.size()), 64'd0);
        end
        repeat (12 * BAUD) @(negedge SYSCLK);
        check({tag, "_no_extra"}, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic dac_count(input string tag, input int expv);
        int ones = 0;
        repeat (256) begin
            @(negedge SYSCLK);
            if (SPEAKER_DAC === 1'b1) ones++;
        end
        check(tag, 64'(ones), 64'(expv));
    endtask

    // UART_0 response receiver, sampling at mid-bit on the falling edge.
    initial begin : uart_mon
        forever begin
            @(negedge SYSCLK);
            if (MSS_RESET_N === 1'b1 && UART_0_TXD === 1'b0) begin
                repeat (BAUD / 2) @(negedge SYSCLK);
                if (UART_0_TXD === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BAUD) @(negedge SYSCLK);
                        mon_b[i] = UART_0_TXD;
                    end
                    repeat (BAUD) @(negedge SYSCLK);
                    if (UART_0_TXD === 1'b1) rx_q.push_back(mon_b);
                end
            end
        end
    end

    // APB slave (ready after wait_cfg wait states) and transfer recorder.
    initial begin : apb_side
        int acc, setc;
        bit prev_sel;
        logic [19:0] ma;
        logic [31:0] md;
        bit mw;
        acc = 0; setc = 0; prev_sel = 1'b0; ma = 20'h0; md = 32'h0; mw = 1'b0;
        MSSPREADY = 1'b0;
        forever begin
            @(negedge SYSCLK);
            if (MSSPSEL === 1'b1 && MSSPENABLE === 1'b1) begin
                MSSPREADY = !never_ready && (acc == wait_cfg);
                acc++;
            end else begin
                MSSPREADY = 1'b0;
            end
            if (MSSPSEL === 1'b1 && MSSPENABLE === 1'b0) setc++;
            if (MSSPSEL === 1'b1) begin ma = MSSPADDR; md = MSSPWDATA; mw = MSSPWRITE; end
            if (prev_sel && MSSPSEL !== 1'b1) begin
                q_addr.push_back(ma); q_data.push_back(md); q_wr.push_back(mw);
                q_set.push_back(setc); q_acc.push_back(acc);
                acc = 0; setc = 0;
            end
            prev_sel = (MSSPSEL === 1'b1);
        end
    end

    initial begin : main
        bit   seen_high;
        time  t0;
        int   budget, pick;
        logic [7:0]  c, db;
        logic [23:0] a;
        logic [31:0] d;

        MSS_RESET_N = 1'b0; UART_0_RXD = 1'b1; UART_1_RXD = 1'b1; SPI_0_DI = 1'b0; VAREF0 = 1'b0;
        gpi = 4'b0000; MSSPRDATA = 32'h0; MSSPSLVERR = 1'b0;

        // Reset phase: outputs at their cleared values while reset is held for 1000 ns.
        #500;
        check("rst_psel", 64'(MSSPSEL), 64'd0);
        check("rst_penable", 64'(MSSPENABLE), 64'd0);
        check("rst_paddr", 64'(MSSPADDR), 64'd0);
        check("rst_txd0", 64'(UART_0_TXD), 64'd1);
        check("rst_txd1", 64'(UART_1_TXD), 64'd1);
        check("rst_dac", 64'(SPEAKER_DAC), 64'd0);
        check("spi_pins", 64'({spi_ss, spi_clk, SPI_0_DO}), 64'h4);
        seen_high = 1'b0;
        while ($time < 1000) begin
            @(negedge SYSCLK);
            if (M2F_RESET_N !== 1'b0) seen_high = 1'b1;
        end
        check("m2f_low_in_reset", 64'(seen_high), 64'd0);
        MSS_RESET_N = 1'b1;
        @(posedge SYSCLK); #1;
        check("m2f_edge1", 64'(M2F_RESET_N), 64'd0);
        @(posedge SYSCLK); #1;
        check("m2f_edge2", 64'(M2F_RESET_N), 64'd1);
        @(posedge FAB_CLK); t0 = $time;
        @(posedge FAB_CLK);
        check("fab_clk_period_ns", 64'($time - t0), 64'd100);
        repeat (4) @(negedge SYSCLK);

        // Directed commands.
        run_cmd("w_dir", 8'h57, 24'h001004, 32'hDEADBEEF, 8'h00);
        check("hold_addr", 64'(MSSPADDR), 64'h01004);
        check("hold_wdata", 64'(MSSPWDATA), 64'hDEADBEEF);
        check("hold_write", 64'(MSSPWRITE), 64'd1);
        never_ready = 1'b1;
        run_cmd("r_timeout", 8'h52, 24'h000008, 32'h0, 8'h00);
        never_ready = 1'b0;
        wait_cfg = 3; MSSPRDATA = 32'h12345678;
        run_cmd("r_data", 8'h52, 24'h0ABCDE, 32'h0, 8'h00);
        MSSPSLVERR = 1'b1;
        run_cmd("r_slverr", 8'h52, 24'h000040, 32'h0, 8'h00);
        run_cmd("w_slverr", 8'h57, 24'h000044, 32'h01020304, 8'h00);
        MSSPSLVERR = 1'b0; wait_cfg = 0;
        gpi = 4'b1001;
        run_cmd("g_dir", 8'h47, 24'h0, 32'h0, 8'h00);
        run_cmd("bad_cmd", 8'h00, 24'h0, 32'h0, 8'h00);
        run_cmd("d_dir", 8'h44, 24'h0, 32'h0, 8'h40);
        dac_count("dac_density_40", DAC_EN ? 64 : 0);

        // Reset in the middle of a stalled APB read must abort it silently.
        never_ready = 1'b1;
        rx_q.delete();
        send_cmd(8'h52, 24'h000100, 32'h0, 8'h00);
        budget = 64;
        while (MSSPENABLE !== 1'b1 && budget > 0) begin
            @(negedge SYSCLK);
            budget--;
        end
        check("midrst_access_seen", 64'(MSSPENABLE), 64'd1);
        repeat (10) @(negedge SYSCLK);
        MSS_RESET_N = 1'b0; #1;
        check("midrst_psel", 64'(MSSPSEL), 64'd0);
        check("midrst_penable", 64'(MSSPENABLE), 64'd0);
        check("midrst_m2f", 64'(M2F_RESET_N), 64'd0);
        repeat (5) @(negedge SYSCLK);
        MSS_RESET_N = 1'b1; never_ready = 1'b0;
        repeat (TMO + 40 * BAUD) @(negedge SYSCLK);
        check("midrst_no_bytes", 64'(rx_q.size()), 64'd0);
        check("midrst_bus_idle", 64'(MSSPSEL), 64'd0);
        dac_count("dac_cleared_by_reset", 0);

        // Randomized commands against the model.
        for (int k = 0; k < 10; k++) begin
            pick = int'($urandom_range(0, 4));
            a = 24'($urandom); d = $urandom; db = 8'($urandom);
            wait_cfg = int'($urandom_range(0, 4));
            MSSPSLVERR = ($urandom_range(0, 3) == 0);
            MSSPRDATA = $urandom;
            gpi = 4'($urandom_range(0, 15));
            case (pick)
                0: c = 8'h57;
                1: c = 8'h52;
                2: c = 8'h47;
                3: c = 8'h44;
                default: begin
                    c = 8'($urandom);
                    while (c == 8'h57 || c == 8'h52 || c == 8'h47 || c == 8'h44) c = 8'($urandom);
                end
            endcase
            run_cmd("rnd", c, a, d, db);
            if (c == 8'h44) dac_count("rnd_dac_density", DAC_EN ? int'(db) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
